joystick_input_conditioner: RTL and testbench
=============================================

// Module: joystick_input_conditioner
// PURPOSE
//  Front end for the game's joystick/button inputs. Synchronises and debounces 4 raw
//  active-low direction buttons and a raw pause button. Drives the game core's active-low
//  i_Push[3:0] and level i_Pause, plus a one-cycle direction event for other consumers.
//  Sits between the board pins and the snake game top.
// PARAMETERS
//  DEB_CLK      500_000  stable cycles required before a debounced level changes (10 ms @ 50 MHz)
//  SYNC_STAGES  2        flip-flop stages in each input synchroniser (>=2)
//  CNT_W        20       debounce counter width; must satisfy 2**CNT_W > DEB_CLK
// PORTS
//  i_Clk       in   1  system clock (single clock domain)
//  i_Rst       in   1  asynchronous, active-low reset
//  i_Btn       in   4  raw direction buttons, active-low, asynchronous to i_Clk; [0..3] = dir 0..3
//  i_PauseBtn  in   1  raw pause button, active-low, asynchronous
//  o_Push      out  4  debounced direction levels, active-low (1 = released)
//  o_Pause     out  1  pause request level to game core (1 = paused)
//  o_DirValid  out  1  one-cycle pulse: a new direction press was accepted
//  o_Dir       out  2  index of accepted direction; valid while o_DirValid=1, else held
// BEHAVIOUR
//  Reset (async, i_Rst=0): sync chains=1, counters=0, o_Push=4'b1111, o_Pause=0,
//   o_DirValid=0, o_Dir=0; the btn_debounce FSM enters REL. Reset mid-bounce discards
//   partial counts. After release, the first edge loads from a clean state.
//  Per input (5 instances): FSM states REL, PRESS_CHK, PRS, REL_CHK.
//   REL: synced=0 -> PRESS_CHK, cnt=0.
//   PRESS_CHK: synced=1 -> REL (bounce, cnt=0); cnt==DEB_CLK-1 -> PRS; else cnt+1.
//   PRS: synced=1 -> REL_CHK, cnt=0.
//   REL_CHK: synced=0 -> PRS; cnt==DEB_CLK-1 -> REL; else cnt+1.
//   Debounced level = 0 in PRS/REL_CHK, 1 in REL/PRESS_CHK. Registered output.
//  Latency: a clean raw edge is seen on o_Push exactly SYNC_STAGES+DEB_CLK+1 cycles later.
//   A glitch shorter than DEB_CLK synced cycles never reaches o_Push.
//  Press event: the cycle a direction's FSM enters PRS gives o_DirValid=1 on the next edge,
//   with o_Dir=that index. Simultaneous entries: the lowest index wins, matching core priority.
//   Losers produce no event. Their o_Push levels still go low.
//  o_DirValid is never high two consecutive cycles for the same press. No auto-repeat.
//  Counter never wraps: it is held at 0 outside the CHK states and saturates at DEB_CLK-1.
// CONFIGURATION
//  PAUSE_TOGGLE_EN defined: each accepted pause press (REL->PRS) toggles o_Pause.
//   Release has no effect. Toggling is registered, 1 cycle after entering PRS.
//  PAUSE_TOGGLE_EN undefined: o_Pause = ~debounced pause level. The game pauses while the
//   button is held.
// STRUCTURE
//  Shared package/header snake_pkg: FSM encodings (REL=2'd0, PRESS_CHK=2'd1, PRS=2'd2,
//   REL_CHK=2'd3), default DEB_CLK, direction index constants.
//  Sub-module btn_debounce (synchroniser + FSM + counter, outputs o_Level, o_PressPulse).
//   Instantiated 5x. The top holds the priority encoder, event register and pause logic.
// TESTING  (bench uses DEB_CLK=8, SYNC_STAGES=2)
//  1. Hold i_Rst=0, then release, all inputs 1 -> o_Push=4'b1111, o_Pause=0, o_DirValid=0.
//  2. i_Btn[2] 1->0 held -> o_Push[2]=0 exactly 11 cycles after edge.
//     o_DirValid=1 for 1 cycle with o_Dir=2.
//  3. i_Btn[1] bounces 0/1 every 3 cycles for 40 cycles, then stays 1 -> o_Push stays
//     4'b1111, no o_DirValid.
//  4. i_Btn[3] and i_Btn[1] fall on the same cycle -> both o_Push bits go 0 together.
//     Single pulse with o_Dir=1.
//  5. Pause press 20 cycles, release, press again. With PAUSE_TOGGLE_EN: o_Pause 0->1->0.
//     Without it: o_Pause follows the held button each time.
//  6. Assert i_Rst=0 while i_Btn[0] has been low 5 cycles (mid-count), release reset with
//     the button still low -> o_Push[0] goes 0 only 11 cycles after reset release.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings and defaults for the snake game input front end.
// Holds the debounce FSM state encoding, default timing values and direction indices.
package snake_pkg;

  typedef enum logic [1:0] {
    REL       = 2'd0,
    PRESS_CHK = 2'd1,
    PRS       = 2'd2,
    REL_CHK   = 2'd3
  } deb_state_e;

  localparam int DEB_CLK_DEFAULT     = 500_000;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int CNT_W_DEFAULT       = 20;
  localparam int NUM_DIRS            = 4;

  localparam logic [1:0] DIR_0 = 2'd0;
  localparam logic [1:0] DIR_1 = 2'd1;
  localparam logic [1:0] DIR_2 = 2'd2;
  localparam logic [1:0] DIR_3 = 2'd3;

  // A debounced button reads as held in both the settled-pressed and release-check states.
  function automatic logic isPressed(input deb_state_e s);
    return (s == PRS) || (s == REL_CHK);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser plus four-state debounce FSM for one active-low raw button.
// Produces a registered active-low level and a one-cycle pulse on each accepted press.
module btn_debounce
  import snake_pkg::*;
#(
  parameter int DEB_CLK     = DEB_CLK_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_PressPulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CLK - 1);

  logic [SYNC_STAGES-1:0] r_Sync;
  logic                   w_Synced;
  deb_state_e             r_State;
  deb_state_e             w_NextState;
  logic [CNT_W-1:0]       r_Cnt;
  logic [CNT_W-1:0]       w_NextCnt;
  logic                   r_Level;
  logic                   r_PressPulse;
  logic                   w_LevelNext;
  logic                   w_PressNext;

  // Idle level of the synchroniser is 1 so reset never looks like a press.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_Sync <= '1;
    end else begin
      r_Sync <= {r_Sync[SYNC_STAGES-2:0], i_Raw};
    end
  end

  assign w_Synced = r_Sync[SYNC_STAGES-1];

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_State      <= REL;
      r_Cnt        <= '0;
      r_Level      <= 1'b1;
      r_PressPulse <= 1'b0;
    end else begin
      r_State      <= w_NextState;
      r_Cnt        <= w_NextCnt;
      r_Level      <= w_LevelNext;
      r_PressPulse <= w_PressNext;
    end
  end

  // Counter only runs in the check states and stops at CNT_MAX, so it can never wrap.
  always_comb begin
    w_NextState = r_State;
    w_NextCnt   = '0;
    case (r_State)
      REL: begin
        if (!w_Synced) w_NextState = PRESS_CHK;
      end
      PRESS_CHK: begin
        if (w_Synced)              w_NextState = REL;
        else if (r_Cnt == CNT_MAX) w_NextState = PRS;
        else                       w_NextCnt   = r_Cnt + CNT_W'(1);
      end
      PRS: begin
        if (w_Synced) w_NextState = REL_CHK;
      end
      REL_CHK: begin
        if (!w_Synced)             w_NextState = PRS;
        else if (r_Cnt == CNT_MAX) w_NextState = REL;
        else                       w_NextCnt   = r_Cnt + CNT_W'(1);
      end
      default: w_NextState = REL;
    endcase
  end

  always_comb begin
    w_LevelNext = ~isPressed(w_NextState);
    w_PressNext = (w_NextState == PRS) && (r_State == PRESS_CHK);
  end

  assign o_Level      = r_Level;
  assign o_PressPulse = r_PressPulse;

endmodule

// File: rtl/joystick_input_conditioner.sv
// Debounces four direction buttons and a pause button for the snake game core.
// Define PAUSE_TOGGLE_EN to make each pause press toggle o_Pause instead of following the button.
module joystick_input_conditioner
  import snake_pkg::*;
#(
  parameter int DEB_CLK     = DEB_CLK_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [NUM_DIRS-1:0] i_Btn,
  input  logic                i_PauseBtn,
  output logic [NUM_DIRS-1:0] o_Push,
  output logic                o_Pause,
  output logic                o_DirValid,
  output logic [1:0]          o_Dir
);

  logic [NUM_DIRS-1:0] w_DirLevel;
  logic [NUM_DIRS-1:0] w_DirPress;
  logic                w_PauseLevel;
  logic                w_PausePress;
  logic                w_AnyPress;
  logic [1:0]          w_PressIdx;
  logic                r_DirValid;
  logic [1:0]          r_Dir;

  for (genvar g = 0; g < NUM_DIRS; g++) begin : g_dir
    btn_debounce #(
      .DEB_CLK     (DEB_CLK),
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_deb (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_Raw        (i_Btn[g]),
      .o_Level      (w_DirLevel[g]),
      .o_PressPulse (w_DirPress[g])
    );
  end

  btn_debounce #(
    .DEB_CLK     (DEB_CLK),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) u_pause_deb (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_Raw        (i_PauseBtn),
    .o_Level      (w_PauseLevel),
    .o_PressPulse (w_PausePress)
  );

  assign o_Push = w_DirLevel;

  // Lowest index wins on simultaneous presses, matching the core's own priority.
  always_comb begin
    w_AnyPress = |w_DirPress;
    w_PressIdx = DIR_0;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (w_DirPress[i]) w_PressIdx = 2'(i);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_DirValid <= 1'b0;
      r_Dir      <= DIR_0;
    end else begin
      r_DirValid <= w_AnyPress;
      if (w_AnyPress) r_Dir <= w_PressIdx;
    end
  end

  assign o_DirValid = r_DirValid;
  assign o_Dir      = r_Dir;

`ifdef PAUSE_TOGGLE_EN
  logic r_Pause;

  // A press pulse always coincides with a low level; the level term is a redundant guard.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_Pause <= 1'b0;
    end else if (w_PausePress && !w_PauseLevel) begin
      r_Pause <= ~r_Pause;
    end
  end

  assign o_Pause = r_Pause;
`else
  // The press pulse only occurs while the level is low, so OR-ing it in changes nothing.
  assign o_Pause = ~w_PauseLevel | w_PausePress;
`endif

endmodule

// File: tb/tb_joystick_input_conditioner.sv
// Directed bench for joystick_input_conditioner with DEB_CLK=8, SYNC_STAGES=2.
// Expected pause behaviour follows whether PAUSE_TOGGLE_EN is defined for the build.
module tb_joystick_input_conditioner;

  logic       i_Clk;
  logic       i_Rst;
  logic [3:0] i_Btn;
  logic       i_PauseBtn;
  logic [3:0] o_Push;
  logic       o_Pause;
  logic       o_DirValid;
  logic [1:0] o_Dir;

  int total = 0;
  int bad = 0;
  int dirPulses = 0;
  int pulseMark = 0;

  joystick_input_conditioner #(
    .DEB_CLK     (8),
    .SYNC_STAGES (2),
    .CNT_W       (4)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Btn      (i_Btn),
    .i_PauseBtn (i_PauseBtn),
    .o_Push     (o_Push),
    .o_Pause    (o_Pause),
    .o_DirValid (o_DirValid),
    .o_Dir      (o_Dir)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Counts every cycle the event output is high so spurious or doubled pulses show up.
  always @(negedge i_Clk) begin
    if (o_DirValid === 1'b1) dirPulses++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycles(input int n);
    repeat (n) @(posedge i_Clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [3:0] btn, input logic pause);
    i_Btn      = btn;
    i_PauseBtn = pause;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset with everything released.
    i_Rst = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    stepCycles(3);
    checkOutput("rst_push", 8'(o_Push), 8'h0f);
    checkOutput("rst_pause", 8'(o_Pause), 8'h00);
    checkOutput("rst_dirvalid", 8'(o_DirValid), 8'h00);
    checkOutput("rst_dir", 8'(o_Dir), 8'h00);
    i_Rst = 1'b1;
    stepCycles(4);
    checkOutput("idle_push", 8'(o_Push), 8'h0f);
    checkOutput("idle_dirvalid", 8'(o_DirValid), 8'h00);

    // Clean press on direction 2: o_Push[2] falls 11 cycles after the edge.
    pulseMark = dirPulses;
    applyStimulus(4'b1011, 1'b1);
    stepCycles(10);
    checkOutput("d2_push_c10", 8'(o_Push), 8'h0f);
    stepCycles(1);
    checkOutput("d2_push_c11", 8'(o_Push), 8'h0b);
    checkOutput("d2_valid_c11", 8'(o_DirValid), 8'h00);
    stepCycles(1);
    checkOutput("d2_valid_c12", 8'(o_DirValid), 8'h01);
    checkOutput("d2_dir_c12", 8'(o_Dir), 8'h02);
    stepCycles(1);
    checkOutput("d2_valid_c13", 8'(o_DirValid), 8'h00);
    checkOutput("d2_dir_hold", 8'(o_Dir), 8'h02);
    stepCycles(5);
    checkOutput("d2_pulses", 8'(dirPulses - pulseMark), 8'h01);
    applyStimulus(4'b1111, 1'b1);
    stepCycles(10);
    checkOutput("d2_rel_c10", 8'(o_Push), 8'h0b);
    stepCycles(1);
    checkOutput("d2_rel_c11", 8'(o_Push), 8'h0f);
    stepCycles(4);

    // Bouncing direction 1: runs of 3 never satisfy the 8-cycle window.
    pulseMark = dirPulses;
    for (int k = 0; k < 40; k++) begin
      i_Btn[1] = ((k / 3) % 2) != 0;
      stepCycles(1);
      if (o_Push !== 4'b1111) checkOutput("bounce_push_mid", 8'(o_Push), 8'h0f);
    end
    applyStimulus(4'b1111, 1'b1);
    stepCycles(15);
    checkOutput("bounce_push", 8'(o_Push), 8'h0f);
    checkOutput("bounce_pulses", 8'(dirPulses - pulseMark), 8'h00);

    // Directions 3 and 1 together: both levels fall, one event with index 1.
    pulseMark = dirPulses;
    applyStimulus(4'b0101, 1'b1);
    stepCycles(11);
    checkOutput("dual_push", 8'(o_Push), 8'h05);
    stepCycles(1);
    checkOutput("dual_valid", 8'(o_DirValid), 8'h01);
    checkOutput("dual_dir", 8'(o_Dir), 8'h01);
    stepCycles(5);
    checkOutput("dual_pulses", 8'(dirPulses - pulseMark), 8'h01);
    applyStimulus(4'b1111, 1'b1);
    stepCycles(15);
    checkOutput("dual_rel_push", 8'(o_Push), 8'h0f);

    // Pause: press 20 cycles, release, press again.
    applyStimulus(4'b1111, 1'b0);
    stepCycles(11);
`ifdef PAUSE_TOGGLE_EN
    checkOutput("pause_p1_c11", 8'(o_Pause), 8'h00);
`else
    checkOutput("pause_p1_c11", 8'(o_Pause), 8'h01);
`endif
    stepCycles(1);
    checkOutput("pause_p1_c12", 8'(o_Pause), 8'h01);
    stepCycles(8);
    applyStimulus(4'b1111, 1'b1);
    stepCycles(11);
`ifdef PAUSE_TOGGLE_EN
    checkOutput("pause_rel", 8'(o_Pause), 8'h01);
`else
    checkOutput("pause_rel", 8'(o_Pause), 8'h00);
`endif
    stepCycles(5);
    applyStimulus(4'b1111, 1'b0);
    stepCycles(12);
`ifdef PAUSE_TOGGLE_EN
    checkOutput("pause_p2", 8'(o_Pause), 8'h00);
`else
    checkOutput("pause_p2", 8'(o_Pause), 8'h01);
`endif
    applyStimulus(4'b1111, 1'b1);
    stepCycles(15);

    // Reset in the middle of a count on direction 0, released with the button still low.
    applyStimulus(4'b1110, 1'b1);
    stepCycles(5);
    i_Rst = 1'b0;
    #1;
    checkOutput("midrst_push", 8'(o_Push), 8'h0f);
    stepCycles(3);
    i_Rst = 1'b1;
    stepCycles(10);
    checkOutput("midrst_c10", 8'(o_Push), 8'h0f);
    stepCycles(1);
    checkOutput("midrst_c11", 8'(o_Push), 8'h0e);
    stepCycles(1);
    checkOutput("midrst_valid", 8'(o_DirValid), 8'h01);
    checkOutput("midrst_dir", 8'(o_Dir), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
